// File: rtl/player_physics.sv
// Per-frame player motion: latches keys on frame_tick, then resolves a horizontal
// move and a vertical move/ground check through a request/acknowledge map probe.
module player_physics #(
    parameter int HALF_W    = 17,
    parameter int HALF_H    = 34,
    parameter int MOVE_STEP = 2,
    parameter int JUMP_V    = 9,
    parameter int GRAVITY   = 1,
    parameter int VMAX      = 8,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       frame_tick,
    input  logic       level_restart,
    input  logic [9:0] start_x,
    input  logic [8:0] start_y,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    output logic       probe_req,
    output logic [9:0] probe_x,
    output logic [8:0] probe_y,
    input  logic       probe_ack,
    input  logic       probe_hit,
    output logic [9:0] player_x,
    output logic [8:0] player_y,
    output logic       on_ground,
    output logic       busy,
    output logic       update_done,
    output logic       frame_overrun
);
    typedef enum logic [1:0] {IDLE, PROBE_X, PROBE_Y, COMMIT} state_t;

    localparam logic signed [10:0] X_MIN   = 11'(HALF_W);
    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - 1 - HALF_W);
    localparam logic signed [10:0] Y_MIN   = 11'(HALF_H);
    localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H - 1 - HALF_H);
    localparam logic signed [3:0]  VX_STEP = 4'(MOVE_STEP);
    localparam logic signed [4:0]  VY_JUMP = -5'(JUMP_V);
    localparam logic signed [4:0]  VY_GRAV = 5'(GRAVITY);
    localparam logic signed [4:0]  VY_MAX  = 5'(VMAX);

    state_t            state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic signed [4:0] vy_q, vy_d;
    logic signed [3:0] vx_q, vx_d;
    logic              og_q, og_d;
    logic              req_q, req_d;
    logic [9:0]        px_q, px_d;
    logic [8:0]        py_q, py_d;
    logic              ovr_q, ovr_d;

    logic signed [10:0] cx, cy;
    logic               x_oor, y_oor, y_resolve, y_hit;

    // Apply gravity to a falling/rising speed, saturating at the terminal velocity.
    function automatic logic signed [4:0] add_gravity(input logic signed [4:0] v);
        logic signed [5:0] s;
        s = $signed({v[4], v}) + $signed({VY_GRAV[4], VY_GRAV});
        if (s > $signed({VY_MAX[4], VY_MAX}))
            return VY_MAX;
        return s[4:0];
    endfunction

    always_comb begin
        cx = $signed({1'b0, x_q}) + $signed({{7{vx_q[3]}}, vx_q});
        if (vy_q == 5'sd0)
            cy = $signed({2'b00, y_q}) + 11'sd1;
        else
            cy = $signed({2'b00, y_q}) + $signed({{6{vy_q[4]}}, vy_q});
        x_oor = (cx < X_MIN) || (cx > X_MAX);
        y_oor = (cy < Y_MIN) || (cy > Y_MAX);
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        vy_d      = vy_q;
        vx_d      = vx_q;
        og_d      = og_q;
        req_d     = req_q;
        px_d      = px_q;
        py_d      = py_q;
        ovr_d     = ovr_q;
        y_resolve = 1'b0;
        y_hit     = 1'b1;

        if (frame_tick && state_q != IDLE)
            ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    if (key_right && !key_left)
                        vx_d = VX_STEP;
                    else if (key_left && !key_right)
                        vx_d = -VX_STEP;
                    else
                        vx_d = 4'sd0;
                    if (key_jump && og_q)
                        vy_d = VY_JUMP;
                    state_d = (vx_d != 4'sd0) ? PROBE_X : PROBE_Y;
                end
            end
            PROBE_X: begin
                // Out-of-screen candidates count as a wall hit and skip the map query.
                if (req_q) begin
                    if (probe_ack) begin
                        if (!probe_hit)
                            x_d = cx[9:0];
                        req_d   = 1'b0;
                        state_d = PROBE_Y;
                    end
                end else if (x_oor) begin
                    state_d = PROBE_Y;
                end else begin
                    req_d = 1'b1;
                    px_d  = cx[9:0];
                    py_d  = y_q;
                end
            end
            PROBE_Y: begin
                if (req_q) begin
                    if (probe_ack) begin
                        y_resolve = 1'b1;
                        y_hit     = probe_hit;
                        req_d     = 1'b0;
                    end
                end else if (y_oor) begin
                    y_resolve = 1'b1;
                end else begin
                    req_d = 1'b1;
                    px_d  = x_q;
                    py_d  = cy[8:0];
                end
                if (y_resolve) begin
                    if (vy_q != 5'sd0) begin
                        if (!y_hit) begin
                            y_d  = cy[8:0];
                            og_d = 1'b0;
                            vy_d = add_gravity(vy_q);
                        end else begin
                            vy_d = 5'sd0;
                            og_d = !vy_q[4];
                        end
                    end else if (y_hit) begin
                        og_d = 1'b1;
                    end else begin
                        og_d = 1'b0;
                        vy_d = VY_GRAV;
                    end
                    state_d = COMMIT;
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Restart abandons any outstanding probe; a late ack then meets req_q=0.
        if (level_restart) begin
            state_d = IDLE;
            x_d     = start_x;
            y_d     = start_y;
            vy_d    = 5'sd0;
            og_d    = 1'b0;
            req_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            x_q     <= start_x;
            y_q     <= start_y;
            vy_q    <= 5'sd0;
            og_q    <= 1'b0;
            req_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            og_q    <= og_d;
            req_q   <= req_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        vx_q <= vx_d;
        px_q <= px_d;
        py_q <= py_d;
    end

    assign probe_req     = req_q;
    assign probe_x       = px_q;
    assign probe_y       = py_q;
    assign player_x      = x_q;
    assign player_y      = y_q;
    assign on_ground     = og_q;
    assign busy          = (state_q == PROBE_X) || (state_q == PROBE_Y);
    assign update_done   = (state_q == COMMIT);
    assign frame_overrun = ovr_q;
endmodule

// File: tb/tb_player_physics.sv
// Scoreboard bench for player_physics: a reference model queues expected probes and
// frame results; the bench acts as the map responder and checks them as they appear.
module tb_player_physics;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       level_restart = 1'b0;
    logic [9:0] start_x = 10'd100;
    logic [8:0] start_y = 9'd300;
    logic       key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
    logic       probe_req;
    logic [9:0] probe_x;
    logic [8:0] probe_y;
    logic       probe_ack = 1'b0, probe_hit = 1'b0;
    logic [9:0] player_x;
    logic [8:0] player_y;
    logic       on_ground, busy, update_done, frame_overrun;

    always #5 clk = ~clk;

    player_physics dut (
        .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .level_restart(level_restart),
        .start_x(start_x), .start_y(start_y),
        .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
        .probe_req(probe_req), .probe_x(probe_x), .probe_y(probe_y),
        .probe_ack(probe_ack), .probe_hit(probe_hit),
        .player_x(player_x), .player_y(player_y), .on_ground(on_ground),
        .busy(busy), .update_done(update_done), .frame_overrun(frame_overrun)
    );

    typedef struct { int x; int y; bit hit; } probe_t;
    typedef struct { int x; int y; bit og; } res_t;
    probe_t pq[$];
    res_t   rq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int mx, my, mvy;
    bit mog, mov;

    // Reference model of one frame; queues the probes it expects and the committed result.
    task automatic model_frame(input bit l, input bit r, input bit j, input bit hx, input bit hy);
        int vx, cx, cy;
        bit hit;
        probe_t p;
        res_t e;
        vx = (r && !l) ? 2 : ((l && !r) ? -2 : 0);
        if (j && mog) mvy = -9;
        if (vx != 0) begin
            cx = mx + vx;
            if (!(cx < 17 || cx > 622)) begin
                p.x = cx; p.y = my; p.hit = hx;
                pq.push_back(p);
                if (!hx) mx = cx;
            end
        end
        cy = (mvy != 0) ? my + mvy : my + 1;
        if (cy < 34 || cy > 445) hit = 1'b1;
        else begin
            hit = hy;
            p.x = mx; p.y = cy; p.hit = hy;
            pq.push_back(p);
        end
        if (mvy != 0) begin
            if (!hit) begin
                my = cy; mog = 1'b0; mvy = (mvy + 1 > 8) ? 8 : mvy + 1;
            end else begin
                mog = (mvy > 0); mvy = 0;
            end
        end else if (hit) mog = 1'b1;
        else begin
            mog = 1'b0; mvy = 1;
        end
        e.x = mx; e.y = my; e.og = mog;
        rq.push_back(e);
    endtask

    task automatic run_frame(input bit l, input bit r, input bit j, input bit hx, input bit hy,
                             input int delay, input bit mid_tick);
        probe_t p;
        res_t e;
        bit done, used_mid;
        int cyc;
        logic [9:0] px0;
        logic [8:0] py0;
        model_frame(l, r, j, hx, hy);
        if (mid_tick) mov = 1'b1;
        key_left = l; key_right = r; key_jump = j;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        done = 1'b0; used_mid = 1'b0; cyc = 0;
        while (!done && cyc < 200) begin
            if (update_done) begin
                done = 1'b1;
                if (rq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL result_queue: update_done with no expected result");
                end else begin
                    e = rq.pop_front();
                    n_cmp++;
                    if (player_x !== 10'(e.x) || player_y !== 9'(e.y) || on_ground !== e.og) begin
                        n_bad++;
                        $display("FAIL frame_result: got x=%0d y=%0d og=%0b, want x=%0d y=%0d og=%0b",
                                 player_x, player_y, on_ground, e.x, e.y, e.og);
                    end
                end
                if (delay == 0 && !mid_tick) begin
                    n_cmp++;
                    if (cyc > 6) begin
                        n_bad++;
                        $display("FAIL latency: got %0d cycles, want <= 7", cyc + 1);
                    end
                end
            end else if (probe_req && !probe_ack) begin
                if (pq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_probe: got probe at (%0d,%0d), want none", probe_x, probe_y);
                    p.x = probe_x; p.y = probe_y; p.hit = 1'b0;
                end else begin
                    p = pq.pop_front();
                    n_cmp++;
                    if (probe_x !== 10'(p.x) || probe_y !== 9'(p.y)) begin
                        n_bad++;
                        $display("FAIL probe_coord: got (%0d,%0d), want (%0d,%0d)", probe_x, probe_y, p.x, p.y);
                    end
                end
                px0 = probe_x; py0 = probe_y;
                for (int i = 0; i < delay; i++) begin
                    @(negedge clk);
                    frame_tick = (mid_tick && !used_mid && i == 1);
                    if (i == 2) used_mid = 1'b1;
                    n_cmp++;
                    if (probe_req !== 1'b1 || probe_x !== px0 || probe_y !== py0 || busy !== 1'b1) begin
                        n_bad++;
                        $display("FAIL probe_hold: got req=%0b (%0d,%0d) busy=%0b, want req=1 (%0d,%0d) busy=1",
                                 probe_req, probe_x, probe_y, busy, px0, py0);
                    end
                end
                frame_tick = 1'b0;
                probe_ack = 1'b1;
                probe_hit = p.hit;
            end else begin
                probe_ack = 1'b0;
                probe_hit = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        probe_ack = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_timeout: got no update_done within 200 cycles, want one");
            pq.delete(); rq.delete();
        end
        n_cmp++;
        if (update_done !== 1'b0 || busy !== 1'b0 || pq.size() != 0 || frame_overrun !== mov) begin
            n_bad++;
            $display("FAIL frame_tail: got done=%0b busy=%0b pending_probes=%0d ovr=%0b, want 0 0 0 %0b",
                     update_done, busy, pq.size(), frame_overrun, mov);
            pq.delete();
        end
    endtask

    task automatic restart_to(input int x, input int y);
        start_x = 10'(x); start_y = 9'(y);
        level_restart = 1'b1;
        @(negedge clk);
        level_restart = 1'b0;
        mx = x; my = y; mvy = 0; mog = 1'b0;
        n_cmp++;
        if (player_x !== 10'(x) || player_y !== 9'(y) || on_ground !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_load: got x=%0d y=%0d og=%0b busy=%0b, want x=%0d y=%0d og=0 busy=0",
                     player_x, player_y, on_ground, busy, x, y);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; start_x = 10'd100; start_y = 9'd300;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (player_x !== 10'd100 || player_y !== 9'd300 || on_ground !== 1'b0 || probe_req !== 1'b0 ||
            update_done !== 1'b0 || frame_overrun !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got x=%0d y=%0d og=%0b req=%0b done=%0b ovr=%0b busy=%0b, want 100 300 0 0 0 0 0",
                     player_x, player_y, on_ground, probe_req, update_done, frame_overrun, busy);
        end
        rstn = 1'b1;
        @(negedge clk);
        mx = 100; my = 300; mvy = 0; mog = 1'b0; mov = 1'b0;
    endtask

    task automatic test_walk_ground_jump;
        run_frame(0, 1, 0, 0, 0, 0, 0);   // x=102, vy becomes 1
        run_frame(0, 0, 0, 0, 1, 0, 0);   // probe at y+1 confirms vy=1; floor lands
        run_frame(0, 0, 0, 0, 1, 0, 0);   // ground check with vy=0
        run_frame(0, 0, 1, 0, 0, 0, 0);   // jump to y=291, vy=-8
        run_frame(0, 0, 0, 0, 1, 0, 0);   // ceiling hit at y-8
        run_frame(0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_x_boundary;
        restart_to(22, 300);
        run_frame(1, 0, 0, 0, 1, 0, 0);
        restart_to(18, 300);
        run_frame(1, 0, 0, 0, 1, 0, 0);
        restart_to(621, 300);
        run_frame(0, 1, 0, 0, 1, 0, 0);
        restart_to(300, 300);
        run_frame(0, 1, 0, 1, 1, 0, 0);
        run_frame(1, 1, 0, 0, 1, 0, 0);
    endtask

    task automatic test_y_boundary;
        restart_to(300, 445);
        run_frame(0, 0, 0, 0, 0, 0, 0);
        restart_to(300, 40);
        run_frame(0, 0, 0, 0, 1, 0, 0);
        run_frame(0, 0, 1, 0, 0, 0, 0);
        run_frame(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_saturation;
        restart_to(300, 100);
        repeat (12) run_frame(0, 0, 0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 0, 1, 0, 0);
        run_frame(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_overrun;
        restart_to(300, 300);
        run_frame(0, 1, 0, 0, 1, 5, 1);
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (probe_req !== 1'b0 || busy !== 1'b0 || update_done !== 1'b0) begin
                n_bad++;
                $display("FAIL overrun_dropped: got req=%0b busy=%0b done=%0b, want all 0",
                         probe_req, busy, update_done);
            end
        end
    endtask

    task automatic test_restart;
        int cyc;
        frame_tick = 1'b1; key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;
        @(negedge clk);
        frame_tick = 1'b0;
        cyc = 0;
        while (!probe_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (probe_req !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_setup: got req=%0b, want 1", probe_req);
        end
        start_x = 10'd200; start_y = 9'd250;
        level_restart = 1'b1;
        @(negedge clk);
        level_restart = 1'b0;
        n_cmp++;
        if (probe_req !== 1'b0 || player_x !== 10'd200 || player_y !== 9'd250 ||
            on_ground !== 1'b0 || busy !== 1'b0 || update_done !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_abort: got req=%0b x=%0d y=%0d og=%0b busy=%0b done=%0b, want 0 200 250 0 0 0",
                     probe_req, player_x, player_y, on_ground, busy, update_done);
        end
        probe_ack = 1'b1; probe_hit = 1'b0;
        @(negedge clk);
        probe_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (update_done !== 1'b0 || probe_req !== 1'b0 || busy !== 1'b0 ||
                player_x !== 10'd200 || player_y !== 9'd250) begin
                n_bad++;
                $display("FAIL late_ack: got done=%0b req=%0b busy=%0b x=%0d y=%0d, want 0 0 0 200 250",
                         update_done, probe_req, busy, player_x, player_y);
            end
        end
        mx = 200; my = 250; mvy = 0; mog = 1'b0;
        run_frame(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_restart_with_tick;
        start_x = 10'd150; start_y = 9'd200;
        key_right = 1'b1;
        frame_tick = 1'b1; level_restart = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; level_restart = 1'b0;
        repeat (3) begin
            n_cmp++;
            if (busy !== 1'b0 || probe_req !== 1'b0 || update_done !== 1'b0 ||
                player_x !== 10'd150 || player_y !== 9'd200) begin
                n_bad++;
                $display("FAIL restart_wins: got busy=%0b req=%0b done=%0b x=%0d y=%0d, want 0 0 0 150 200",
                         busy, probe_req, update_done, player_x, player_y);
            end
            @(negedge clk);
        end
        mx = 150; my = 200; mvy = 0; mog = 1'b0;
    endtask

    task automatic test_back_to_back;
        restart_to(320, 200);
        for (int k = 0; k < 10; k++) begin
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
        end
    endtask

    initial begin
        test_reset;
        test_walk_ground_jump;
        test_x_boundary;
        test_y_boundary;
        test_saturation;
        test_restart;
        test_restart_with_tick;
        test_back_to_back;
        test_overrun;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
